// File: rtl/bcd_xs3_codec_if.sv
// Handshake bundle for the BCD/Excess-3 codec: input word channel and result channel.
interface bcd_xs3_codec_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [4*DIGITS-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err_mask;
  logic                  out_err;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_mask, out_err
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_mask, out_err
  );
endinterface

// File: rtl/bcd_xs3_codec.sv
// Multi-digit BCD <-> Excess-3 converter, one digit per clock, LSD first.
// The captured word shifts right each CONV cycle so the converter always sees
// nibble 0; results shift in from the top so digit 0 lands at the bottom after
// DIGITS cycles.

module bcd_xs3_digit (
  input  logic       mode,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       err
);
  // Single-digit rule: encode d+3 for 0..9, decode d-3 for 3..12, else 0 + error.
  always_comb begin
    q   = 4'h0;
    err = 1'b0;
    if (!mode) begin
      if (d <= 4'd9) q = d + 4'd3;
      else           err = 1'b1;
    end else begin
      if (d >= 4'd3 && d <= 4'd12) q = d - 4'd3;
      else                         err = 1'b1;
    end
  end
endmodule

module bcd_xs3_codec #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_xs3_codec_if.slave        bus,
  output logic                  busy
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state, next_state;
  logic [W-1:0]        word_q;
  logic [W-1:0]        result_q;
  logic                mode_q;
  logic [DIGITS-1:0]   mask_q;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          dig_q;
  logic                dig_err;
  logic                accept;
  logic                last;
  logic [W+3:0]        res_shift;
  logic [DIGITS:0]     mask_shift;

  bcd_xs3_digit u_digit (
    .mode (mode_q),
    .d    (word_q[3:0]),
    .q    (dig_q),
    .err  (dig_err)
  );

  assign accept     = (state == IDLE) && bus.in_valid;
  assign last       = (idx == IDX_W'(DIGITS - 1));
  assign res_shift  = {dig_q, result_q};
  assign mask_shift = {dig_err, mask_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: accept in IDLE, walk all digits in CONV, hold DONE until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)  next_state = CONV;
      CONV:    if (last)          next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one converted digit per CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      mask_q   <= '0;
      idx      <= '0;
    end else begin
      if (accept) begin
        word_q   <= bus.in_data;
        mode_q   <= bus.in_mode;
        result_q <= '0;
        mask_q   <= '0;
        idx      <= '0;
      end else if (state == CONV) begin
        word_q   <= word_q >> 4;
        result_q <= res_shift[W+3:4];
        mask_q   <= mask_shift[DIGITS:1];
        idx      <= last ? '0 : idx + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.out_valid    = (state == DONE);
  assign bus.out_data     = result_q;
  assign bus.out_err_mask = mask_q;
  assign bus.out_err      = |mask_q;
  assign busy             = (state != IDLE);
endmodule

// File: tb/tb_bcd_xs3_codec.sv
// Bench for bcd_xs3_codec: three instances (DIGITS=4,1,8) sharing one stimulus
// path selected by 'sel'; expectations from a table and a digit-arithmetic model.
module tb_bcd_xs3_codec;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          sel;
  logic        dv, dm, ordy;
  logic [31:0] dd;

  bcd_xs3_codec_if #(.DIGITS(4)) if4 ();
  bcd_xs3_codec_if #(.DIGITS(1)) if1 ();
  bcd_xs3_codec_if #(.DIGITS(8)) if8 ();
  logic busy4, busy1, busy8;

  bcd_xs3_codec #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .busy(busy4));
  bcd_xs3_codec #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busy1));
  bcd_xs3_codec #(.DIGITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave), .busy(busy8));

  assign if4.in_valid = dv && (sel == 0);
  assign if1.in_valid = dv && (sel == 1);
  assign if8.in_valid = dv && (sel == 2);
  assign if4.in_mode = dm;   assign if1.in_mode = dm;   assign if8.in_mode = dm;
  assign if4.in_data = dd[15:0];
  assign if1.in_data = dd[3:0];
  assign if8.in_data = dd;
  assign if4.out_ready = ordy; assign if1.out_ready = ordy; assign if8.out_ready = ordy;

  logic        rd_ready, rd_valid, rd_err, rd_busy;
  logic [31:0] rd_data;
  logic [7:0]  rd_mask;

  always_comb begin
    rd_ready = if4.in_ready; rd_valid = if4.out_valid; rd_err = if4.out_err;
    rd_busy = busy4; rd_data = {16'h0, if4.out_data}; rd_mask = {4'h0, if4.out_err_mask};
    if (sel == 1) begin
      rd_ready = if1.in_ready; rd_valid = if1.out_valid; rd_err = if1.out_err;
      rd_busy = busy1; rd_data = {28'h0, if1.out_data}; rd_mask = {7'h0, if1.out_err_mask};
    end else if (sel == 2) begin
      rd_ready = if8.in_ready; rd_valid = if8.out_valid; rd_err = if8.out_err;
      rd_busy = busy8; rd_data = if8.out_data; rd_mask = if8.out_err_mask;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ndig(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 8;
  endfunction

  // Reference: decimal digit arithmetic, {mask[7:0], data[31:0]}.
  function automatic logic [39:0] model(input int nd, input logic mode, input logic [31:0] d);
    logic [31:0] res = 0;
    logic [7:0]  msk = 0;
    for (int i = 0; i < nd; i++) begin
      int v = int'((d >> (4 * i)) & 32'hF);
      if (!mode && v <= 9)              res |= 32'(v + 3) << (4 * i);
      else if (mode && v >= 3 && v <= 12) res |= 32'(v - 3) << (4 * i);
      else                              msk |= 8'(1 << i);
    end
    return {msk, res};
  endfunction

  task automatic wait_ready(input string nm);
    int k = 0;
    while (!rd_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk({nm, " in_ready"}, 40'(rd_ready), 40'd1);
  endtask

  task automatic accept(input logic mode, input logic [31:0] d);
    dm = mode; dd = d; dv = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0; dd = $urandom; dm = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int lat = 0;
    while (!rd_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, 40'(lat), 40'(exp_lat));
  endtask

  task automatic xact(input int s, input logic mode, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic [7:0] exp_m, input string nm);
    sel = s; ordy = 1'b1;
    wait_ready(nm);
    accept(mode, d);
    wait_valid(nm, ndig(s));
    chk({nm, " data"}, 40'(rd_data), 40'(exp_d));
    chk({nm, " mask"}, 40'(rd_mask), 40'(exp_m));
    chk({nm, " err"},  40'(rd_err),  40'(exp_m != 0));
    @(posedge clk); #1;
    chk({nm, " back to idle"}, {38'h0, rd_ready, rd_valid}, 40'b10);
  endtask

  typedef struct {
    int          s;
    logic        mode;
    logic [31:0] din;
    logic [31:0] exp_d;
    logic [7:0]  exp_m;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 1'b0, 32'h1234,     32'h4567,     8'h0};
    vecs[1] = '{0, 1'b1, 32'hC963,     32'h9630,     8'h0};
    vecs[2] = '{0, 1'b1, 32'h4567,     32'h1234,     8'h0};
    vecs[3] = '{0, 1'b0, 32'h9A05,     32'hC038,     8'h4};
    vecs[4] = '{0, 1'b1, 32'h3C21,     32'h0900,     8'h3};
    vecs[5] = '{1, 1'b0, 32'h7,        32'hA,        8'h0};
    vecs[6] = '{1, 1'b1, 32'hA,        32'h7,        8'h0};
    vecs[7] = '{2, 1'b0, 32'h98765432, 32'hCBA98765, 8'h0};
    vecs[8] = '{2, 1'b1, 32'hCBA98765, 32'h98765432, 8'h0};

    sel = 0; dv = 1'b0; dm = 1'b0; dd = '0; ordy = 1'b1;
    rst_n = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk($sformatf("reset[%0d] state", s), {36'h0, rd_ready, rd_busy, rd_valid, rd_err}, 40'b1000);
      chk($sformatf("reset[%0d] data", s), {rd_mask, rd_data}, 40'h0);
    end
    sel = 0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      xact(vecs[i].s, vecs[i].mode, vecs[i].din, vecs[i].exp_d, vecs[i].exp_m, $sformatf("vec%0d", i));

    // Random words against the model on every width.
    for (int i = 0; i < 60; i++) begin
      int          s = i % 3;
      logic        m = 1'($urandom_range(0, 1));
      logic [31:0] d = $urandom;
      logic [39:0] e;
      if (s == 0) d &= 32'hFFFF;
      if (s == 1) d &= 32'hF;
      e = model(ndig(s), m, d);
      xact(s, m, d, e[31:0], e[39:32], $sformatf("rnd%0d", i));
    end

    // Backpressure: result held in DONE while inputs churn.
    sel = 0; ordy = 1'b0;
    wait_ready("bp");
    accept(1'b0, 32'h1234);
    wait_valid("bp", 4);
    for (int i = 0; i < 5; i++) begin
      dv = 1'($urandom_range(0, 1)); dd = $urandom; dm = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d data", i), 40'(rd_data), 40'h4567);
      chk($sformatf("bp hold%0d hs", i), {38'h0, rd_ready, rd_valid}, 40'b01);
    end
    dv = 1'b0; ordy = 1'b1;
    @(posedge clk); #1;
    chk("bp release", {37'h0, rd_ready, rd_valid, rd_busy}, 40'b100);
    @(posedge clk); #1;
    chk("bp no second accept", {37'h0, rd_ready, rd_valid, rd_busy}, 40'b100);

    // Reset in the middle of CONV.
    wait_ready("rst");
    accept(1'b0, 32'h1234);
    @(posedge clk); #1;
    chk("rst pre busy", 40'(rd_busy), 40'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst abort state", {36'h0, rd_ready, rd_busy, rd_valid, rd_err}, 40'b1000);
    chk("rst abort data", {rd_mask, rd_data}, 40'h0);
    @(negedge clk); rst_n = 1'b1;
    xact(0, 1'b0, 32'h0000, 32'h3333, 8'h0, "post rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
